// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M definitions: opcode fields, FSM state encoding and
// small decode helpers used by the multiply/divide unit.
package muldiv_unit_pkg;

  // Opcode field values for the M extension
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PREP = 2'b01;
  localparam logic [1:0] ST_CALC = 2'b10;
  localparam logic [1:0] ST_FIX  = 2'b11;

  typedef logic [2:0] funct3_t;

  // All divide/remainder operations have funct3[2] set
  function automatic logic op_is_div(input funct3_t f);
    return f[2];
  endfunction

  // Operand A is interpreted as signed for these operations
  function automatic logic a_is_signed(input funct3_t f);
    return (f == FUNCT3_MULH) || (f == FUNCT3_MULHSU) ||
           (f == FUNCT3_DIV)  || (f == FUNCT3_REM);
  endfunction

  // Operand B is interpreted as signed for these operations
  function automatic logic b_is_signed(input funct3_t f);
    return (f == FUNCT3_MULH) || (f == FUNCT3_DIV) || (f == FUNCT3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_iter_datapath.sv
// Iterative datapath of the multiply/divide unit. Holds the latched
// operation and operands, performs one shift-add (multiply) or one
// restoring shift-subtract (divide) step per CALC cycle, and produces
// the sign-corrected, operation-selected result for the FIX cycle.
module muldiv_iter_datapath
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  prep,
  input  logic                  step,
  input  logic [CNT_WIDTH-1:0]  cnt,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  fast_path,
  output logic [DATA_WIDTH-1:0] fix_value
);

  localparam int W = DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] MIN_INT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  funct3_t          op_reg, op_next;
  logic [W-1:0]     a_reg, a_next;
  logic [W-1:0]     b_reg, b_next;
  // Multiply: full 2W product. Divide: {remainder, quotient}.
  logic [2*W-1:0]   acc_reg, acc_next;
  logic             sign_a_reg, sign_a_next;
  logic             sign_b_reg, sign_b_next;

  // One-hot select of the operand bit handled in this iteration (MSB first)
  logic [W-1:0] bit_mask;
  for (genvar gi = 0; gi < W; gi++) begin : g_bit_mask
    assign bit_mask[gi] = (cnt == CNT_WIDTH'(gi));
  end

  logic a_bit;
  logic b_bit;
  assign a_bit = |(a_reg & bit_mask);
  assign b_bit = |(b_reg & bit_mask);

  // Restoring division step: bring in the next dividend bit and try a subtract
  logic [W:0] rem_shift;
  logic [W:0] rem_trial;
  logic       rem_ge;
  assign rem_shift = {acc_reg[2*W-1:W], a_bit};
  assign rem_trial = rem_shift - {1'b0, b_reg};
  assign rem_ge    = ~rem_trial[W];

  // Multiply step addend
  logic [2*W-1:0] mul_addend;
  assign mul_addend = b_bit ? {{W{1'b0}}, a_reg} : '0;

  // Cases resolved without iterating (evaluated on the raw latched operands)
  logic div_by_zero;
  logic div_overflow;
  assign div_by_zero  = (b_reg == '0);
  assign div_overflow = op_is_div(op_reg) && b_is_signed(op_reg) &&
                        (a_reg == MIN_INT) && (b_reg == '1);
  assign fast_path    = op_is_div(op_reg) && (div_by_zero || div_overflow);

  logic raw_sign_a;
  logic raw_sign_b;
  assign raw_sign_a = a_is_signed(op_reg) & a_reg[W-1];
  assign raw_sign_b = b_is_signed(op_reg) & b_reg[W-1];

  // Next-state logic for operands, accumulator and recorded signs
  always_comb begin
    op_next     = op_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    acc_next    = acc_reg;
    sign_a_next = sign_a_reg;
    sign_b_next = sign_b_reg;
    if (load) begin
      op_next     = funct3;
      a_next      = rs1_data;
      b_next      = rs2_data;
      acc_next    = '0;
      sign_a_next = 1'b0;
      sign_b_next = 1'b0;
    end else if (prep) begin
      if (fast_path) begin
        // Preload the architecturally defined answer; no sign fixup needed
        sign_a_next = 1'b0;
        sign_b_next = 1'b0;
        acc_next    = div_by_zero ? {a_reg, {W{1'b1}}} : {{W{1'b0}}, MIN_INT};
      end else begin
        // Magnitudes only from here on; MIN_INT stays 0x80..0 as unsigned
        sign_a_next = raw_sign_a;
        sign_b_next = raw_sign_b;
        a_next      = raw_sign_a ? -a_reg : a_reg;
        b_next      = raw_sign_b ? -b_reg : b_reg;
        acc_next    = '0;
      end
    end else if (step) begin
      if (op_is_div(op_reg)) begin
        acc_next[2*W-1:W] = rem_ge ? rem_trial[W-1:0] : rem_shift[W-1:0];
        acc_next[W-1:0]   = acc_reg[W-1:0] | (bit_mask & {W{rem_ge}});
      end else begin
        acc_next = {acc_reg[2*W-2:0], 1'b0} + mul_addend;
      end
    end
  end

  // Datapath state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
    end else begin
      op_reg     <= op_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      acc_reg    <= acc_next;
      sign_a_reg <= sign_a_next;
      sign_b_reg <= sign_b_next;
    end
  end

  // Sign correction of the magnitude results
  logic           neg_result;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_raw;
  logic [W-1:0]   rem_raw;
  logic [W-1:0]   quot_fix;
  logic [W-1:0]   rem_fix;
  assign neg_result = sign_a_reg ^ sign_b_reg;
  assign quot_raw   = acc_reg[W-1:0];
  assign rem_raw    = acc_reg[2*W-1:W];
  assign prod_fix   = neg_result ? -acc_reg : acc_reg;
  assign quot_fix   = neg_result ? -quot_raw : quot_raw;
  assign rem_fix    = sign_a_reg ? -rem_raw : rem_raw;

  // Select the architectural result for the latched operation
  always_comb begin
    fix_value = rem_fix;
    case (op_reg)
      FUNCT3_MUL:                              fix_value = prod_fix[W-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: fix_value = prod_fix[2*W-1:W];
      FUNCT3_DIV, FUNCT3_DIVU:                 fix_value = quot_fix;
      default:                                 fix_value = rem_fix;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide unit for the EX stage. Owns the
// IDLE/PREP/CALC/FIX sequencer, the iteration counter, flush handling
// and the busy/done handshake; arithmetic lives in the datapath.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  kill,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  logic [1:0]            state_reg, state_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] result_reg;
  logic [DATA_WIDTH-1:0] fix_value;
  logic                  fast_path;
  logic                  load;
  logic                  prep;
  logic                  step;

  assign load = (state_reg == ST_IDLE) && start && !kill;
  assign prep = (state_reg == ST_PREP);
  assign step = (state_reg == ST_CALC);

  muldiv_iter_datapath #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .prep      (prep),
    .step      (step),
    .cnt       (cnt_reg),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .fast_path (fast_path),
    .fix_value (fix_value)
  );

  // Sequencer: kill from any state returns to IDLE without a done
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (kill) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (start) state_next = ST_PREP;
        ST_PREP: begin
          if (fast_path) begin
            state_next = ST_FIX;
          end else begin
            state_next = ST_CALC;
            cnt_next   = '1;
          end
        end
        ST_CALC: begin
          if (cnt_reg == '0) state_next = ST_FIX;
          else               cnt_next   = cnt_reg - 1'b1;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State, counter and held result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (done) result_reg <= fix_value;
    end
  end

  // The fixed-up value is presented during FIX and captured to be held
  // afterwards; a flush or reset in FIX leaves the previous result showing.
  assign busy   = (state_reg != ST_IDLE);
  assign done   = (state_reg == ST_FIX) && !kill && !reset;
  assign result = done ? fix_value : result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, handshake,
// kill and reset scenarios, then random operations against a reference
// model built from plain integer arithmetic.
`timescale 1ns/1ps
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_result = '0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t dir_vecs [12];

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .kill     (kill),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics with wide integer arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    int              ia, ib, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      FUNCT3_MUL:    begin up = ua * ub; return up[31:0]; end
      FUNCT3_MULH:   begin p = sa * sb; return p[63:32]; end
      FUNCT3_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      FUNCT3_MULHU:  begin up = ua * ub; return up[63:32]; end
      FUNCT3_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = ia / ib;
        return q;
      end
      FUNCT3_DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      FUNCT3_REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = ia % ib;
        return q;
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  // Expected done latency: 2 for the divide special cases, 34 otherwise
  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'h0 ||
        ((f == FUNCT3_DIV || f == FUNCT3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 2;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation and follow it through to done plus one idle cycle.
  // ghost_cyc > 0 pulses start in that cycle while the unit is busy.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input int ghost_cyc);
    int          cyc;
    int          done_cyc;
    int          n_done;
    int          busy_bad;
    logic [31:0] got;
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    funct3   = 3'($urandom);
    rs1_data = $urandom;
    rs2_data = $urandom;
    cyc = 1; done_cyc = -1; n_done = 0; busy_bad = 0; got = '0;
    while (cyc <= 60) begin
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          got      = result;
        end
      end
      if (busy !== ((cyc <= exp_lat) ? 1'b1 : 1'b0)) busy_bad++;
      if (done_cyc >= 0 && cyc > done_cyc) break;
      start = (cyc == ghost_cyc) ? 1'b1 : 1'b0;
      tick();
      cyc++;
    end
    start = 1'b0;
    check({tag, "/latency"}, 64'(done_cyc), 64'(exp_lat));
    check({tag, "/result"}, {32'h0, got}, {32'h0, exp_res});
    check({tag, "/done_count"}, 64'(n_done), 64'd1);
    check({tag, "/busy_profile"}, 64'(busy_bad), 64'd0);
    $display("op %-12s f3=%0d a=%08h b=%08h result=%08h expected=%08h done_cycle=%0d",
             tag, f, a, b, got, exp_res, done_cyc);
    last_result = exp_res;
  endtask

  initial begin
    int          n;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    dir_vecs[0]  = '{FUNCT3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    dir_vecs[1]  = '{FUNCT3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    dir_vecs[2]  = '{FUNCT3_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    dir_vecs[3]  = '{FUNCT3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    dir_vecs[4]  = '{FUNCT3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    dir_vecs[5]  = '{FUNCT3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    dir_vecs[6]  = '{FUNCT3_DIVU,   32'd100,        32'd7,         32'd14,        34};
    dir_vecs[7]  = '{FUNCT3_REMU,   32'd100,        32'd7,         32'd2,         34};
    dir_vecs[8]  = '{FUNCT3_DIVU,   32'h0000_0055,  32'd0,         32'hFFFF_FFFF, 2};
    dir_vecs[9]  = '{FUNCT3_REMU,   32'h0000_1234,  32'd0,         32'h0000_1234, 2};
    dir_vecs[10] = '{FUNCT3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};
    dir_vecs[11] = '{FUNCT3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 2};

    // Reset state
    reset = 1'b1; start = 1'b0; kill = 1'b0;
    funct3 = '0; rs1_data = '0; rs2_data = '0;
    tick(); tick(); tick();
    check("reset/busy", {63'h0, busy}, 64'd0);
    check("reset/done", {63'h0, done}, 64'd0);
    check("reset/result", {32'h0, result}, 64'd0);
    reset = 1'b0;
    tick();
    check("idle/busy", {63'h0, busy}, 64'd0);

    // Directed arithmetic vectors, including the fast paths
    for (int i = 0; i < 12; i++)
      run_op($sformatf("dir%0d", i), dir_vecs[i].f, dir_vecs[i].a, dir_vecs[i].b,
             dir_vecs[i].r, dir_vecs[i].lat, 0);

    // start pulsed at cycle 5 while busy is ignored
    run_op("ghost_start", FUNCT3_MUL, 32'd1234, 32'd5678, 32'd7006652, 34, 5);

    // kill during CALC: no done, result held, next start accepted at once
    funct3 = FUNCT3_MUL; rs1_data = 32'd123; rs2_data = 32'd456; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int c = 1; c < 10; c++) begin
      if (done === 1'b1) n++;
      tick();
    end
    kill = 1'b1;
    #1;
    if (done === 1'b1) n++;
    tick();
    kill = 1'b0;
    check("kill/busy", {63'h0, busy}, 64'd0);
    check("kill/done", {63'h0, done}, 64'd0);
    check("kill/result_held", {32'h0, result}, {32'h0, last_result});
    check("kill/no_done", 64'(n), 64'd0);
    run_op("after_kill", FUNCT3_DIVU, 32'd100, 32'd7, 32'd14, 34, 0);

    // kill in FIX suppresses done and the result write
    funct3 = FUNCT3_MULHU; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 34; c++) tick();
    check("fixkill/would_be_done", {63'h0, done}, 64'd1);
    kill = 1'b1;
    #1;
    check("fixkill/done", {63'h0, done}, 64'd0);
    check("fixkill/result_live", {32'h0, result}, {32'h0, last_result});
    tick();
    kill = 1'b0;
    check("fixkill/busy", {63'h0, busy}, 64'd0);
    check("fixkill/result_held", {32'h0, result}, {32'h0, last_result});

    // start and kill together in IDLE: request dropped
    funct3 = FUNCT3_MUL; rs1_data = 32'd3; rs2_data = 32'd3; start = 1'b1; kill = 1'b1;
    tick();
    start = 1'b0; kill = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy === 1'b1 || done === 1'b1) n++;
      tick();
    end
    check("startkill/stays_idle", 64'(n), 64'd0);
    check("startkill/result", {32'h0, result}, {32'h0, last_result});

    // reset at cycle 20 of an operation
    funct3 = FUNCT3_DIV; rs1_data = 32'd1000; rs2_data = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    check("midreset/busy_before", {63'h0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset/busy", {63'h0, busy}, 64'd0);
    check("midreset/done", {63'h0, done}, 64'd0);
    check("midreset/result", {32'h0, result}, 64'd0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) n++;
      tick();
    end
    check("midreset/no_done", 64'(n), 64'd0);
    last_result = '0;

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op($sformatf("rnd%0d", i), rf, ra, rb, ref_op(rf, ra, rb), ref_lat(rf, ra, rb),
             (i % 4 == 0) ? int'($urandom_range(1, 34)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle RV32M execute unit, the responder side of the EX-stage operand/result interface.
- The EX stage issues two operands and funct3 with a start pulse. The unit holds busy, which the hazard logic turns into a pipeline stall. It returns a 32-bit result with a one-cycle done pulse.
- It sits beside the ALU in EX. Its result is muxed into the EX/MEM result path when done is high.

Parameters:
- DATA_WIDTH, 32: operand/result width. Only 32 is supported.
- CNT_WIDTH, 5: iteration counter width, equal to log2(DATA_WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe. Accepted only in IDLE.
- funct3  input  3  M-extension operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  input  32  operand A (multiplicand/dividend).
- rs2_data  input  32  operand B (multiplier/divisor).
- kill  input  1  pipeline flush. Aborts any operation in flight.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse; result is valid in the same cycle.
- result  output  32  registered result. Holds its value until the next done.

Behaviour:
- Reset values: state IDLE, busy 0, done 0, result 0, counter 0, internal registers 0. Reset aborts any operation in flight with no done.
- States: IDLE, PREP, CALC, FIX.
- IDLE:
  - start=1 and kill=0: latch funct3 and both operands, go to PREP.
  - Otherwise stay in IDLE.
- PREP (1 cycle):
  - Record operand signs. A is signed for MULH, MULHSU, DIV, REM. B is signed for MULH, DIV, REM. Replace signed operands with their absolute values.
  - Divide-by-zero and signed-overflow fast paths go straight to FIX. All other cases load counter=31 and go to CALC.
- CALC (32 cycles, counter 31..0):
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, 32-bit remainder plus quotient.
  - At counter==0, go to FIX.
- FIX (1 cycle):
  - Sign correction: negate the product if sign_a^sign_b. Negate the quotient if sign_a^sign_b. The remainder takes the sign of the dividend.
  - Select the output: MUL takes product[31:0]; MULH, MULHSU, MULHU take product[63:32].
  - Write result, drive done=1, go to IDLE.
- Latency, with start sampled at edge 0:
  - Normal path: done high in cycle 34, busy high in cycles 1..34.
  - Fast path: done high in cycle 2.
- Division special cases (RISC-V defined; no trap):
  - B==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give A.
  - DIV with A=0x80000000, B=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Handshake:
  - start while busy is ignored and does not queue.
  - The EX stage holds its operands stable only until start is accepted, because all operands are latched in IDLE.
- kill:
  - In any state, the next state is IDLE, busy falls the next cycle, no done is issued, and result is unchanged.
  - kill and start in the same IDLE cycle: kill wins and the request is dropped.
  - kill in FIX: done is suppressed and result is not written.
- done never asserts two cycles in a row. A new start is accepted in the cycle after done.
- Arithmetic: absolute value of 0x80000000 is kept as unsigned 0x80000000. All negation is two's complement over the full width (64 bits for the product).

Decomposition:
- Shared header beside opcodes.v:
  - M-extension funct7 (0000001) and the eight FUNCT3_MUL*/DIV*/REM* defines.
  - State encoding constants: IDLE=2'b00, PREP=2'b01, CALC=2'b10, FIX=2'b11.
- One natural sub-module, muldiv_iter_datapath: operand/accumulator registers, one shift-add or shift-subtract step per cycle, sign fixup.
- Top level keeps the FSM, counter, kill handling and done/busy generation.

Test Plan:
1. MUL, A=7, B=0xFFFFFFFD (-3), start at cycle 0 -> busy in cycles 1..34, done only in cycle 34, result 0xFFFFFFEB.
2. MULH and MULHU, A=B=0x80000000 -> MULH 0x40000000, MULHU 0x40000000. MULHSU with A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV and REM, A=0xFFFFFFF9 (-7), B=2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF. DIVU with A=100, B=7 -> 14; REMU -> 2.
4. Fast paths, each done in cycle 2:
   - DIVU with B=0 -> 0xFFFFFFFF.
   - REMU with A=0x1234, B=0 -> 0x1234.
   - DIV with A=0x80000000, B=0xFFFFFFFF -> 0x80000000.
   - REM with the same operands -> 0.
5. MUL started, kill at cycle 10 -> busy 0 from cycle 11, no done, result keeps its previous value. New start at cycle 11 is accepted, and its done arrives at cycle 45.
6. start pulsed at cycle 5 during a busy operation -> ignored, exactly one done. reset at cycle 20 -> busy=done=result=0 from cycle 21, no done afterwards. Simultaneous start+kill in IDLE -> stays IDLE.
